// File: rtl/pc_next_unit.sv
// Program-counter stage: WIDTH-bit PC register plus its dedicated next-PC adder.
// Each rising edge the PC takes the reset vector, holds (stall), loads a
// redirect target, or advances by INCREMENT. A registered flag reports whether
// the most recently loaded PC is not word aligned.
module pc_next_unit #(
    parameter int                 WIDTH        = 64,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(1'b0),
    parameter logic [WIDTH-1:0]   INCREMENT    = WIDTH'(3'd4)
) (
    input  logic              clk,
    input  logic              pc_reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WIDTH-1:0]  redirect_target,
    output logic [WIDTH-1:0]  pc_out,
    output logic [WIDTH-1:0]  pc_plus_inc,
    output logic              misaligned
);

    // True when an address is not aligned to a 4-byte instruction boundary.
    function automatic logic addr_misaligned(input logic [WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic [WIDTH-1:0] pc_r;
    logic             misaligned_r;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] pc_next_s;
    logic             misaligned_next_s;

    // Next-PC adder; the carry out of the top bit is discarded so the PC wraps.
    always_comb begin
        pc_inc_s = pc_r + INCREMENT;
    end

    // Select the next PC below reset priority: stall holds, redirect loads the
    // target, otherwise advance. A redirect seen during a stall is dropped.
    always_comb begin
        pc_next_s         = pc_r;
        misaligned_next_s = misaligned_r;
        if (stall) begin
            pc_next_s         = pc_r;
            misaligned_next_s = misaligned_r;
        end else if (redirect) begin
            pc_next_s         = redirect_target;
            misaligned_next_s = addr_misaligned(redirect_target);
        end else begin
            pc_next_s         = pc_inc_s;
            misaligned_next_s = addr_misaligned(pc_inc_s);
        end
    end

    // PC and alignment-flag registers with synchronous reset to the reset vector.
    always_ff @(posedge clk) begin
        if (pc_reset) begin
            pc_r         <= RESET_VECTOR;
            misaligned_r <= 1'b0;
        end else begin
            pc_r         <= pc_next_s;
            misaligned_r <= misaligned_next_s;
        end
    end

    assign pc_out      = pc_r;
    assign pc_plus_inc = pc_inc_s;
    assign misaligned  = misaligned_r;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: two instances (reset vector 0 and
// 0x8000) share the same stimulus and are compared against a behavioural model.
module tb_pc_next_unit;

    logic        clk;
    logic        pc_reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_target;
    logic [63:0] pc_out_a, pc_plus_inc_a, pc_out_b, pc_plus_inc_b;
    logic        misaligned_a, misaligned_b;

    int errors;
    int checks;

    logic [63:0] model_pc  [2];
    logic        model_mis [2];
    logic [63:0] rst_vec   [2];

    pc_next_unit u_dut_a (
        .clk             (clk),
        .pc_reset        (pc_reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_out          (pc_out_a),
        .pc_plus_inc     (pc_plus_inc_a),
        .misaligned      (misaligned_a)
    );

    pc_next_unit #(.RESET_VECTOR(64'h8000)) u_dut_b (
        .clk             (clk),
        .pc_reset        (pc_reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_out          (pc_out_b),
        .pc_plus_inc     (pc_plus_inc_b),
        .misaligned      (misaligned_b)
    );

    // Free-running clock, 10 time units period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare both instances against the model.
    task automatic check_model(input string tag);
        check_val({tag, "_pc_a"},  pc_out_a,             model_pc[0]);
        check_val({tag, "_inc_a"}, pc_plus_inc_a,        model_pc[0] + 64'd4);
        check_val({tag, "_mis_a"}, 64'(misaligned_a),    64'(model_mis[0]));
        check_val({tag, "_pc_b"},  pc_out_b,             model_pc[1]);
        check_val({tag, "_inc_b"}, pc_plus_inc_b,        model_pc[1] + 64'd4);
        check_val({tag, "_mis_b"}, 64'(misaligned_b),    64'(model_mis[1]));
    endtask

    // Drive inputs at the falling edge, advance the model at the rising edge,
    // then check just after the edge.
    task automatic cycle(input logic r, input logic s, input logic rd,
                         input logic [63:0] tgt, input string tag);
        @(negedge clk);
        pc_reset        = r;
        stall           = s;
        redirect        = rd;
        redirect_target = tgt;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                model_pc[k]  = rst_vec[k];
                model_mis[k] = 1'b0;
            end else if (s) begin
                model_pc[k]  = model_pc[k];
            end else begin
                model_pc[k]  = rd ? tgt : model_pc[k] + 64'd4;
                model_mis[k] = (model_pc[k] % 64'd4) != 64'd0;
            end
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        logic        r, s, rd;
        logic [63:0] tgt;
        errors     = 0;
        checks     = 0;
        rst_vec[0] = 64'h0;
        rst_vec[1] = 64'h8000;
        model_pc[0] = 64'h0; model_pc[1] = 64'h0;
        model_mis[0] = 1'b0; model_mis[1] = 1'b0;
        pc_reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 64'h0;

        // Reset then free-run.
        cycle(1'b1, 1'b0, 1'b0, 64'h0, "rst0");
        cycle(1'b1, 1'b0, 1'b0, 64'h0, "rst1");
        check_val("rst_pc_a_const", pc_out_a, 64'h0);
        check_val("rst_pc_b_const", pc_out_b, 64'h8000);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "run4");
        check_val("run_pc4", pc_out_a, 64'd4);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "run8");
        check_val("run_pc8", pc_out_a, 64'd8);

        // Redirect, then increment.
        cycle(1'b0, 1'b0, 1'b1, 64'h1000, "redir");
        check_val("redir_pc", pc_out_a, 64'h1000);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "post_redir");
        check_val("post_redir_pc", pc_out_a, 64'h1004);

        // Stall with redirect asserted: redirect dropped.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 64'h2000, "stall");
        check_val("stall_hold", pc_out_a, 64'h1004);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "unstall");
        check_val("unstall_pc", pc_out_a, 64'h1008);

        // Wrap-around.
        cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "wrap_ld");
        check_val("wrap_inc", pc_plus_inc_a, 64'h0);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "wrap");
        check_val("wrap_pc", pc_out_a, 64'h0);

        // Misalignment flag.
        cycle(1'b0, 1'b0, 1'b1, 64'h1002, "mis_ld");
        check_val("mis_set", 64'(misaligned_a), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "mis_inc");
        check_val("mis_inc_pc", pc_out_a, 64'h1006);
        check_val("mis_stays", 64'(misaligned_a), 64'd1);
        cycle(1'b0, 1'b0, 1'b1, 64'h3000, "mis_clr");
        check_val("mis_clear", 64'(misaligned_a), 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "to3004");
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "to3008");

        // Reset beats stall and redirect.
        cycle(1'b1, 1'b1, 1'b1, 64'h5000, "rst_prio");
        check_val("rst_prio_a", pc_out_a, 64'h0);
        check_val("rst_prio_b", pc_out_b, 64'h8000);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, "after_rst");
        check_val("after_rst_b", pc_out_b, 64'h8004);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 30);
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cycle(r, s, rd, tgt, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
